cpu_cfg_slave: RTL and testbench
================================

CPU_CFG_SLAVE -- requirements
Module: cpu_cfg_slave

Interface
REQ-001 Parameter DATA_W, default 8, CPU data width in bits; legal range 8..32.
REQ-002 Parameter ADDR_W, default 4, CPU word-address width in bits.
REQ-003 Parameter NUM_CH, default 2, number of FIFO channels served; 4+2*NUM_CH <= 2**ADDR_W is a legal-configuration constraint.
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Rst  input  1  reset; synchronous, active-high.
REQ-006 CS  input  1  chip select; a low-to-high transition, sampled on Clk, starts one access.
REQ-007 Rd_Wr  input  1  1 = read, 0 = write; sampled together with the CS rising edge.
REQ-008 Addr  input  ADDR_W  word address; sampled together with the CS rising edge.
REQ-009 DataIn  input  DATA_W  write data; sampled together with the CS rising edge.
REQ-010 DataOut  output  DATA_W  read data; valid while Ready=1 and held until the next read completes.
REQ-011 Ready  output  1  one-cycle completion pulse for every access, including unmapped ones.
REQ-012 Err  output  1  one-cycle pulse, coincident with Ready, for an unmapped address or a write to a read-only register.
REQ-013 Level  input  NUM_CH*DATA_W  per-channel FIFO fill level; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-014 Ovf  input  NUM_CH  per-channel single-cycle overflow event pulses.
REQ-015 AfThresh  output  NUM_CH*DATA_W  per-channel almost-full thresholds, packed the same way as Level.
REQ-016 Enable  output  1  global enable; equals CTRL bit 0.
REQ-017 SoftRst  output  1  one-cycle soft-reset pulse to the FIFO channels.
REQ-018 Irq  output  1  registered interrupt request.

Function
REQ-019 An access shall start in the cycle where CS is sampled 1 after having been sampled 0; holding CS high shall start no further access.
REQ-020 Ready and Err shall assert exactly one cycle after the access-start cycle; write side-effects shall be visible on the outputs in that same cycle.
REQ-021 Address 0x0 (CTRL, RW): bit0 is Enable; writing 1 to bit1 shall pulse SoftRst for one cycle; bit1 shall always read 0; other bits shall read 0.
REQ-022 Address 0x1 (INT_STAT, W1C): bit c shall be set by Ovf[c] and cleared by writing 1 to bit c; bits at NUM_CH and above shall read 0.
REQ-023 Address 0x2 (INT_MASK, RW): bits [NUM_CH-1:0] are implemented; other bits shall read 0.
REQ-024 Address 0x3 (SCRATCH, RW): full DATA_W width, no side effects.
REQ-025 Address 4+2c (AF_THRESH[c], RW): full DATA_W width, drives AfThresh channel c.
REQ-026 Address 5+2c (LEVEL[c], RO): returns Level channel c as sampled in the access-start cycle.
REQ-027 Unmapped address: read returns 0, write ignored, Err=1.
REQ-028 RO write: the register is unchanged and Err=1.
REQ-029 Same-cycle Ovf[c] and W1C clear of bit c shall leave the bit set (set wins).
REQ-030 Irq shall equal the OR of (INT_STAT & INT_MASK), registered, so it lags any INT_STAT or INT_MASK change by one cycle.
REQ-031 A write access shall leave DataOut unchanged.
REQ-032 SoftRst shall not clear any register in this block.

Reset
REQ-033 With Rst=1 at a clock edge, the following shall be 0 in the next cycle: CTRL, INT_STAT, INT_MASK, SCRATCH, DataOut, Ready, Err, SoftRst, Irq, and the internal CS history.
REQ-034 With Rst=1 at a clock edge, every AF_THRESH register shall be set to 2**DATA_W-2 in the next cycle (for example 0xFE when DATA_W=8).
REQ-035 An access in progress when Rst asserts shall be abandoned: no Ready pulse and no register update.
REQ-036 After Rst deasserts with CS already high, no access shall start until CS has been sampled 0.

Verification
REQ-037 Reset, then read 0x4 and 0x6 -> 0xFE each, Ready one cycle after the CS rise, Err=0.
REQ-038 Write 0x3=0xA5, then read 0x3 -> 0xA5; with CS held high for 5 cycles -> exactly one Ready pulse.
REQ-039 Write INT_MASK=0x01, pulse Ovf[0] -> INT_STAT reads 0x01 and Irq=1 one cycle later; write 0x01 to 0x1 in the same cycle as a second Ovf[0] pulse -> bit stays set.
REQ-040 Write 0x0=0x03 -> Enable=1, SoftRst high for exactly one cycle, CTRL reads 0x01.
REQ-041 Read 0xF (unmapped with NUM_CH=2) -> DataOut=0, Err=1; write 0x5=0x33 -> Err=1 and LEVEL[0] still reads Level.
REQ-042 Assert Rst in the cycle right after a CS rise for a write of 0x3=0x77 -> no Ready pulse, SCRATCH reads 0x00.

Source files
------------

// File: rtl/cpu_cfg_slave.sv
// CPU-side configuration/status register slave serving NUM_CH FIFO channels.
// A CS rising edge captures one access; it completes with Ready/Err one clock later.
module cpu_cfg_slave #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_CH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     CS,
    input  logic                     Rd_Wr,
    input  logic [ADDR_W-1:0]        Addr,
    input  logic [DATA_W-1:0]        DataIn,
    output logic [DATA_W-1:0]        DataOut,
    output logic                     Ready,
    output logic                     Err,
    input  logic [NUM_CH*DATA_W-1:0] Level,
    input  logic [NUM_CH-1:0]        Ovf,
    output logic [NUM_CH*DATA_W-1:0] AfThresh,
    output logic                     Enable,
    output logic                     SoftRst,
    output logic                     Irq
);
    localparam logic [DATA_W-1:0] AF_RST = {{(DATA_W-1){1'b1}}, 1'b0};

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
    state_t state_q, state_d;

    logic              cs_low_q, cs_low_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] lvl_q, lvl_d;
    logic              en_q, en_d;
    logic [NUM_CH-1:0] stat_q, stat_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] af_q [NUM_CH];
    logic [DATA_W-1:0] af_d [NUM_CH];
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              srst_q, srst_d;
    logic              irq_q, irq_d;

    logic              start;
    logic              done;
    logic              wr_en;
    logic              hit;
    logic              ro;
    logic [DATA_W-1:0] rdata;
    logic [NUM_CH-1:0] clr;
    logic [DATA_W-1:0] lvl_ch [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign lvl_ch[g]                    = Level[g*DATA_W +: DATA_W];
        assign AfThresh[g*DATA_W +: DATA_W] = af_q[g];
    end

    // cs_low_q only arms after CS is seen low, so CS held across reset starts nothing
    always_comb begin
        start    = CS && cs_low_q;
        cs_low_d = ~CS;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lvl_d    = lvl_q;
        if (start) begin
            rd_d    = Rd_Wr;
            addr_d  = Addr;
            wdata_d = DataIn;
            lvl_d   = '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (Addr == ADDR_W'(5 + 2*c)) lvl_d = lvl_ch[c];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done      = (state_q == ST_ACCESS);
        wr_en     = done && !rd_q;
        hit       = 1'b1;
        ro        = 1'b0;
        rdata     = '0;
        clr       = '0;
        en_d      = en_q;
        mask_d    = mask_q;
        scratch_d = scratch_q;
        af_d      = af_q;
        srst_d    = 1'b0;
        case (addr_q)
            ADDR_W'(0): begin
                rdata = DATA_W'(en_q);
                if (wr_en) begin
                    en_d   = wdata_q[0];
                    srst_d = wdata_q[1];
                end
            end
            ADDR_W'(1): begin
                rdata = DATA_W'(stat_q);
                if (wr_en) clr = NUM_CH'(wdata_q);
            end
            ADDR_W'(2): begin
                rdata = DATA_W'(mask_q);
                if (wr_en) mask_d = NUM_CH'(wdata_q);
            end
            ADDR_W'(3): begin
                rdata = scratch_q;
                if (wr_en) scratch_d = wdata_q;
            end
            default: begin
                hit = 1'b0;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (addr_q == ADDR_W'(4 + 2*c)) begin
                        hit   = 1'b1;
                        rdata = af_q[c];
                        if (wr_en) af_d[c] = wdata_q;
                    end else if (addr_q == ADDR_W'(5 + 2*c)) begin
                        hit   = 1'b1;
                        ro    = 1'b1;
                        rdata = lvl_q;
                    end
                end
            end
        endcase
        ready_d = done;
        err_d   = done && (!hit || (ro && !rd_q));
        dout_d  = (done && rd_q) ? rdata : dout_q;
        // new overflow events win over a same-cycle W1C clear
        stat_d  = (stat_q & ~clr) | Ovf;
        irq_d   = |(stat_q & mask_q);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            cs_low_q  <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lvl_q     <= '0;
            en_q      <= 1'b0;
            stat_q    <= '0;
            mask_q    <= '0;
            scratch_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) af_q[c] <= AF_RST;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            srst_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_low_q  <= cs_low_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lvl_q     <= lvl_d;
            en_q      <= en_d;
            stat_q    <= stat_d;
            mask_q    <= mask_d;
            scratch_q <= scratch_d;
            af_q      <= af_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            srst_q    <= srst_d;
            irq_q     <= irq_d;
        end
    end

    assign DataOut = dout_q;
    assign Ready   = ready_q;
    assign Err     = err_q;
    assign Enable  = en_q;
    assign SoftRst = srst_q;
    assign Irq     = irq_q;

endmodule

// File: tb/tb_cpu_cfg_slave.sv
// Scoreboard bench for cpu_cfg_slave: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever Ready is seen.
module tb_cpu_cfg_slave;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NUM_CH = 2;

    logic                     Clk = 1'b0;
    logic                     Rst;
    logic                     CS;
    logic                     Rd_Wr;
    logic [ADDR_W-1:0]        Addr;
    logic [DATA_W-1:0]        DataIn;
    logic [DATA_W-1:0]        DataOut;
    logic                     Ready;
    logic                     Err;
    logic [NUM_CH*DATA_W-1:0] Level;
    logic [NUM_CH-1:0]        Ovf;
    logic [NUM_CH*DATA_W-1:0] AfThresh;
    logic                     Enable;
    logic                     SoftRst;
    logic                     Irq;

    cpu_cfg_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
        .Clk(Clk), .Rst(Rst), .CS(CS), .Rd_Wr(Rd_Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Ready(Ready), .Err(Err), .Level(Level), .Ovf(Ovf),
        .AfThresh(AfThresh), .Enable(Enable), .SoftRst(SoftRst), .Irq(Irq)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       err;
        logic       srst;
    } exp_t;
    exp_t sb[$];

    logic       m_en;
    logic [1:0] m_stat;
    logic [1:0] m_mask;
    logic [7:0] m_scr;
    logic [7:0] m_dout;
    logic [7:0] m_af [NUM_CH];

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_en = 1'b0; m_stat = '0; m_mask = '0; m_scr = '0; m_dout = '0;
        for (int c = 0; c < NUM_CH; c++) m_af[c] = 8'hFE;
    endfunction

    // register-map semantics applied directly to the bench's copy of the registers
    function automatic exp_t model(input logic rd, input logic [3:0] a, input logic [7:0] d,
                                   input logic [1:0] ovf);
        exp_t e;
        logic [7:0] rv;
        logic mapped, ro;
        int ch;
        rv = '0; mapped = 1'b1; ro = 1'b0; e.srst = 1'b0; e.cyc = 0;
        ch = (int'(a) - 4) / 2;
        if (a == 0)      rv = {7'b0, m_en};
        else if (a == 1) rv = {6'b0, m_stat};
        else if (a == 2) rv = {6'b0, m_mask};
        else if (a == 3) rv = m_scr;
        else if (int'(a) < 4 + 2*NUM_CH) begin
            if (a[0] == 1'b0) rv = m_af[ch];
            else begin ro = 1'b1; rv = Level[ch*8 +: 8]; end
        end else mapped = 1'b0;
        e.err = !mapped || (ro && !rd);
        if (rd) m_dout = rv;
        else if (mapped && !ro) begin
            if (a == 0) begin m_en = d[0]; e.srst = d[1]; end
            else if (a == 1) m_stat = m_stat & ~d[1:0];
            else if (a == 2) m_mask = d[1:0];
            else if (a == 3) m_scr = d;
            else m_af[ch] = d;
        end
        m_stat = m_stat | ovf;
        e.data = m_dout;
        return e;
    endfunction

    task automatic post_checks();
        check("enable", {31'b0, Enable}, {31'b0, m_en});
        check("irq", {31'b0, Irq}, {31'b0, |(m_stat & m_mask)});
        check("afthresh", {16'b0, AfThresh}, {16'b0, m_af[1], m_af[0]});
    endtask

    task automatic access(input logic rd, input logic [3:0] a, input logic [7:0] d,
                          input int hold, input logic [1:0] ovf);
        exp_t e;
        e = model(rd, a, d, ovf);
        e.cyc = cyc + 2;
        sb.push_back(e);
        CS = 1'b1; Rd_Wr = rd; Addr = a; DataIn = d;
        @(negedge Clk);
        Ovf = ovf;
        @(negedge Clk);
        Ovf = '0;
        for (int i = 2; i < hold; i++) @(negedge Clk);
        CS = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        post_checks();
    endtask

    task automatic pulse_ovf(input logic [1:0] v);
        logic irq_old;
        irq_old = |(m_stat & m_mask);
        Ovf = v;
        @(negedge Clk);
        Ovf = '0;
        check("irq_lag", {31'b0, Irq}, {31'b0, irq_old});
        m_stat = m_stat | v;
        @(negedge Clk);
        check("irq_after_ovf", {31'b0, Irq}, {31'b0, |(m_stat & m_mask)});
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL ready_missing got no Ready expected Ready at cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (Ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL ready_spurious got Ready=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("ready_cycle", cyc, e.cyc);
                check("err", {31'b0, Err}, {31'b0, e.err});
                check("dataout", {24'b0, DataOut}, {24'b0, e.data});
                check("softrst", {31'b0, SoftRst}, {31'b0, e.srst});
            end
        end else begin
            check("err_idle", {31'b0, Err}, 32'd0);
            check("softrst_idle", {31'b0, SoftRst}, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; CS = 1'b0; Rd_Wr = 1'b0; Addr = '0; DataIn = '0;
        Level = 16'h5A3C; Ovf = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_dataout", {24'b0, DataOut}, 32'd0);
        check("rst_ready", {31'b0, Ready}, 32'd0);
        check("rst_irq", {31'b0, Irq}, 32'd0);
        post_checks();

        access(1'b1, 4'h4, 8'h00, 2, 2'b00);
        access(1'b1, 4'h6, 8'h00, 2, 2'b00);
        access(1'b0, 4'h3, 8'hA5, 2, 2'b00);
        access(1'b1, 4'h3, 8'h00, 5, 2'b00);
        access(1'b0, 4'h2, 8'h01, 2, 2'b00);
        pulse_ovf(2'b01);
        access(1'b1, 4'h1, 8'h00, 2, 2'b00);
        access(1'b0, 4'h1, 8'h01, 2, 2'b01);
        access(1'b1, 4'h1, 8'h00, 2, 2'b00);
        access(1'b0, 4'h1, 8'h01, 3, 2'b00);
        access(1'b1, 4'h1, 8'h00, 2, 2'b00);
        access(1'b0, 4'h0, 8'h03, 2, 2'b00);
        access(1'b1, 4'h0, 8'h00, 2, 2'b00);
        access(1'b1, 4'hF, 8'h00, 2, 2'b00);
        access(1'b0, 4'h5, 8'h33, 2, 2'b00);
        access(1'b1, 4'h5, 8'h00, 2, 2'b00);
        access(1'b0, 4'h7, 8'h44, 2, 2'b00);
        access(1'b0, 4'h4, 8'h10, 2, 2'b00);

        // reset lands mid-access with CS still high through and after reset
        CS = 1'b1; Rd_Wr = 1'b0; Addr = 4'h3; DataIn = 8'h77;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        CS = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        post_checks();
        access(1'b1, 4'h3, 8'h00, 2, 2'b00);
        access(1'b1, 4'h4, 8'h00, 2, 2'b00);

        for (int n = 0; n < 80; n++) begin
            Level = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_ovf(2'($urandom));
            access(1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
                   int'($urandom_range(2, 4)),
                   ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00);
        end

        @(negedge Clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
